// File: rtl/codec_serial_slave_if.sv
// Serial audio link between the core's codec port and the CODEC stand-in.
// Carries the I2S-style pins plus the parallel sample/handshake side.
interface codec_serial_slave_if #(
  parameter int SAMPLE_W = 16
);
  logic                RSTn;
  logic                SCLK;
  logic                LRCLK;
  logic                SDin;
  logic                SDout;
  logic [SAMPLE_W-1:0] lft_tx;
  logic [SAMPLE_W-1:0] rht_tx;
  logic                tx_ack;
  logic [SAMPLE_W-1:0] lft_rx;
  logic [SAMPLE_W-1:0] rht_rx;
  logic                rx_valid;
  logic                frame_err;

  modport master (
    output RSTn, SCLK, LRCLK, SDin, lft_tx, rht_tx,
    input  SDout, tx_ack, lft_rx, rht_rx, rx_valid, frame_err
  );

  modport slave (
    input  RSTn, SCLK, LRCLK, SDin, lft_tx, rht_tx,
    output SDout, tx_ack, lft_rx, rht_rx, rx_valid, frame_err
  );
endinterface

// File: rtl/codec_serial_slave.sv
// CODEC-side end of the I2S-style audio link. Oversamples SCLK/LRCLK/SDin on
// clk, deserializes left/right receive words and serializes transmit words
// onto SDout. Never clocks on SCLK.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_IDLE  | after reset; waiting for an LRCLK edge into the left level
//  ST_LEFT  | left half-frame: receive/transmit the left word
//  ST_RIGHT | right half-frame: receive/transmit the right word
module codec_serial_slave #(
  parameter int   SAMPLE_W = 16,
  parameter logic LEFT_LVL = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  codec_serial_slave_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  // bcnt counts SCLK rises in the half (saturating at SAMPLE_W+1),
  // fcnt counts SCLK falls that have driven a data bit (saturating at SAMPLE_W).
  localparam int BW = $clog2(SAMPLE_W + 2);
  localparam int FW = $clog2(SAMPLE_W + 1);
  localparam logic [BW-1:0] B_FULL = BW'(SAMPLE_W + 1);
  localparam logic [BW-1:0] B_LAST = BW'(SAMPLE_W);
  localparam logic [FW-1:0] F_END  = FW'(SAMPLE_W);

  logic [2:0]          sclk_q, lrclk_q, vld_q;
  logic [1:0]          sdin_q;
  logic                sync_ok, sclk_rise, sclk_fall, lr_edge, lr_left, sdin_s;
  logic [1:0]          state, state_nx;
  logic                frm_bad, half_err, rx_done;
  logic [BW-1:0]       bcnt, bcnt_cur;
  logic [FW-1:0]       fcnt, fcnt_cur;
  logic [SAMPLE_W-1:0] sh, lft_word, lft_hold, rht_hold, tx_word, tx_shl;
  logic                sdout_q, tx_ack_q, rx_valid_q, frame_err_q;
  logic [SAMPLE_W-1:0] lft_rx_q, rht_rx_q;

  // Two-flop synchronizers plus history stage; vld_q masks edges until the
  // history stage holds a real pin sample, so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= '0;
      lrclk_q <= '0;
      sdin_q  <= '0;
      vld_q   <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], bus.SCLK};
      lrclk_q <= {lrclk_q[1:0], bus.LRCLK};
      sdin_q  <= {sdin_q[0], bus.SDin};
      vld_q   <= {vld_q[1:0], 1'b1};
    end
  end

  assign sync_ok   = vld_q[2];
  assign sclk_rise = sync_ok &  sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = sync_ok & ~sclk_q[1] &  sclk_q[2];
  assign lr_edge   = sync_ok & (lrclk_q[1] ^ lrclk_q[2]);
  assign lr_left   = (lrclk_q[1] == LEFT_LVL);
  assign sdin_s    = sdin_q[1];

  // An LRCLK edge restarts the half, so an SCLK edge in the same clk counts
  // as the first event of the new half.
  assign bcnt_cur = lr_edge ? '0 : bcnt;
  assign fcnt_cur = lr_edge ? '0 : fcnt;
  assign half_err = lr_edge && (state != ST_IDLE) && (bcnt < B_FULL);
  assign rx_done  = sclk_rise && (state_nx == ST_RIGHT) && (bcnt_cur == B_LAST);
  assign tx_shl   = tx_word << fcnt_cur;

  // Next half-frame and the word to serialize in it.
  always_comb begin
    state_nx = state;
    if (lr_edge) begin
      if (lr_left)
        state_nx = ST_LEFT;
      else if (state == ST_LEFT)
        state_nx = ST_RIGHT;
    end
    tx_word = rht_hold;
    if (lr_edge && lr_left)
      tx_word = bus.lft_tx;
    else if (state_nx == ST_LEFT)
      tx_word = lft_hold;
  end

  // FSM and frame-error tracking. RSTn comes from the master in this clk
  // domain and acts as a synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      frm_bad     <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (!bus.RSTn) begin
      state       <= ST_IDLE;
      frm_bad     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_err_q <= half_err;
      if (lr_edge && lr_left)
        frm_bad <= 1'b0;
      else if (half_err && state == ST_LEFT)
        frm_bad <= 1'b1;
    end
  end

  // Receive: rise #1 is the delay slot, rises #2..#SAMPLE_W+1 shift SDin in;
  // both words publish together on the right word's last rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      sh         <= '0;
      lft_word   <= '0;
      lft_rx_q   <= '0;
      rht_rx_q   <= '0;
      rx_valid_q <= 1'b0;
    end else if (!bus.RSTn) begin
      bcnt       <= '0;
      sh         <= '0;
      lft_word   <= '0;
      lft_rx_q   <= '0;
      rht_rx_q   <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_nx == ST_IDLE)
        bcnt <= '0;
      else if (sclk_rise)
        bcnt <= (bcnt_cur == B_FULL) ? bcnt_cur : bcnt_cur + BW'(1);
      else
        bcnt <= bcnt_cur;
      if (sclk_rise && state_nx != ST_IDLE && bcnt_cur != '0 && bcnt_cur <= B_LAST)
        sh <= {sh[SAMPLE_W-2:0], sdin_s};
      if (lr_edge && !lr_left && state == ST_LEFT && !half_err)
        lft_word <= sh;
      if (rx_done && !frm_bad) begin
        lft_rx_q   <= lft_word;
        rht_rx_q   <= {sh[SAMPLE_W-2:0], sdin_s};
        rx_valid_q <= 1'b1;
      end
    end
  end

  // Transmit: samples latched on left entry; fall #k drives bit SAMPLE_W-k,
  // falls after the word drive 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt     <= '0;
      lft_hold <= '0;
      rht_hold <= '0;
      tx_ack_q <= 1'b0;
      sdout_q  <= 1'b0;
    end else if (!bus.RSTn) begin
      fcnt     <= '0;
      lft_hold <= '0;
      rht_hold <= '0;
      tx_ack_q <= 1'b0;
      sdout_q  <= 1'b0;
    end else begin
      tx_ack_q <= 1'b0;
      if (lr_edge && lr_left) begin
        lft_hold <= bus.lft_tx;
        rht_hold <= bus.rht_tx;
        tx_ack_q <= 1'b1;
      end
      if (state_nx == ST_IDLE) begin
        fcnt    <= '0;
        sdout_q <= 1'b0;
      end else if (sclk_fall) begin
        if (fcnt_cur == F_END) begin
          fcnt    <= fcnt_cur;
          sdout_q <= 1'b0;
        end else begin
          fcnt    <= fcnt_cur + FW'(1);
          sdout_q <= tx_shl[SAMPLE_W-1];
        end
      end else begin
        fcnt <= fcnt_cur;
      end
    end
  end

  assign bus.SDout     = sdout_q;
  assign bus.tx_ack    = tx_ack_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.lft_rx    = lft_rx_q;
  assign bus.rht_rx    = rht_rx_q;

endmodule

// File: tb/tb_codec_serial_slave.sv
// Directed bench for codec_serial_slave: a simple I2S master (SCLK = clk/16,
// LRCLK = clk/1024, LRCLK changes with an SCLK rise) drives the slave and
// captures SDout on SCLK rises #2..#17 of each half.
module tb_codec_serial_slave;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;

  codec_serial_slave_if #(.SAMPLE_W(W)) bus ();

  codec_serial_slave #(.SAMPLE_W(W), .LEFT_LVL(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0, n_rxv = 0, n_ack = 0, n_ferr = 0, t_rxv = 0, t_prev = 0;
  logic [W-1:0] mon_l = '0, mon_r = '0;
  logic sdin_m = 1'b0;
  logic loopback = 1'b0;

  // SDin comes from the master model, or straight back from SDout
  always_comb bus.SDin = loopback ? bus.SDout : sdin_m;

  // pulse monitor
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_valid === 1'b1) begin
      n_rxv  <= n_rxv + 1;
      t_prev <= t_rxv;
      t_rxv  <= cyc;
      mon_l  <= bus.lft_rx;
      mon_r  <= bus.rht_rx;
    end
    if (bus.tx_ack === 1'b1)    n_ack  <= n_ack + 1;
    if (bus.frame_err === 1'b1) n_ferr <= n_ferr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_sdout"},     32'(bus.SDout),     32'd0);
    chk({pfx, "_tx_ack"},    32'(bus.tx_ack),    32'd0);
    chk({pfx, "_rx_valid"},  32'(bus.rx_valid),  32'd0);
    chk({pfx, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    chk({pfx, "_lft_rx"},    32'(bus.lft_rx),    32'd0);
    chk({pfx, "_rht_rx"},    32'(bus.rht_rx),    32'd0);
  endtask

  // One half-frame: nrise SCLK periods, LRCLK set to lvl on the first rise.
  task automatic master_half(input logic lvl, input logic [W-1:0] word, input int nrise,
                             output logic [W-1:0] cap, output int nz);
    cap = '0;
    nz  = 0;
    for (int i = 1; i <= nrise; i++) begin
      @(negedge clk);
      bus.SCLK = 1'b1;
      if (i == 1) bus.LRCLK = lvl;
      if (i >= 2 && i <= 17)
        cap = {cap[W-2:0], bus.SDout};
      else if (i >= 18 && bus.SDout !== 1'b0)
        nz++;
      repeat (7) @(negedge clk);
      @(negedge clk);
      bus.SCLK = 1'b0;
      sdin_m = (i <= 16) ? word[16-i] : 1'b0;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic master_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              output logic [W-1:0] cl, output logic [W-1:0] cr, output int nz);
    int nzl, nzr;
    master_half(1'b1, l, 32, cl, nzl);
    master_half(1'b0, r, 32, cr, nzr);
    nz = nzl + nzr;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: sim time expired before summary");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] cl, cr, lv, rv;
    int nz, a0, r0, f0;

    rst_n = 1'b0;
    bus.RSTn = 1'b1;
    bus.SCLK = 1'b0;
    bus.LRCLK = 1'b0;
    bus.lft_tx = 16'hA5C3;
    bus.rht_tx = 16'h0F0F;
    repeat (4) @(negedge clk);
    chk_zero("por");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // basic rx 8001/7FFE with tx A5C3/0F0F
    master_frame(16'h8001, 16'h7FFE, cl, cr, nz);
    chk("f1_lft_rx", 32'(bus.lft_rx), 32'h8001);
    chk("f1_rht_rx", 32'(bus.rht_rx), 32'h7FFE);
    chk("f1_rxv_cnt", n_rxv, 1);
    chk("f1_cap_l", 32'(cl), 32'hA5C3);
    chk("f1_cap_r", 32'(cr), 32'h0F0F);
    chk("f1_tail_zero", nz, 0);
    chk("f1_ack_cnt", n_ack, 1);
    chk("f1_ferr_cnt", n_ferr, 0);

    // tx changes mid-frame must wait for the next left entry
    bus.lft_tx = 16'h1111;
    bus.rht_tx = 16'h2222;
    fork
      master_frame(16'h1357, 16'h2468, cl, cr, nz);
      begin
        repeat (200) @(negedge clk);
        bus.lft_tx = 16'h3333;
        bus.rht_tx = 16'h4444;
      end
    join
    chk("f2_cap_l", 32'(cl), 32'h1111);
    chk("f2_cap_r", 32'(cr), 32'h2222);
    chk("f2_lft_rx", 32'(bus.lft_rx), 32'h1357);
    chk("f2_rht_rx", 32'(bus.rht_rx), 32'h2468);
    chk("f2_ack_cnt", n_ack, 2);
    chk("f2_rxv_cnt", n_rxv, 2);

    master_frame(16'hFFFF, 16'h0001, cl, cr, nz);
    chk("f3_cap_l", 32'(cl), 32'h3333);
    chk("f3_cap_r", 32'(cr), 32'h4444);
    chk("f3_lft_rx", 32'(bus.lft_rx), 32'hFFFF);
    chk("f3_rht_rx", 32'(bus.rht_rx), 32'h0001);
    chk("f3_tail_zero", nz, 0);

    // async reset mid-frame
    a0 = n_ack;
    r0 = n_rxv;
    fork
      master_frame(16'h0AAA, 16'h0555, cl, cr, nz);
      begin
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    chk("f4_ack_cnt", n_ack, a0 + 1);
    chk("f4_rxv_cnt", n_rxv, r0);
    chk("f4_lft_rx", 32'(bus.lft_rx), 32'h0);
    master_frame(16'h0C0C, 16'h0303, cl, cr, nz);
    chk("f5_ack_cnt", n_ack, a0 + 2);
    chk("f5_rxv_cnt", n_rxv, r0 + 1);
    chk("f5_lft_rx", 32'(bus.lft_rx), 32'h0C0C);
    chk("f5_rht_rx", 32'(bus.rht_rx), 32'h0303);
    chk("f5_cap_l", 32'(cl), 32'h3333);
    chk("f5_cap_r", 32'(cr), 32'h4444);

    // short left half -> frame_err, frame dropped, next frame good
    f0 = n_ferr;
    r0 = n_rxv;
    master_half(1'b1, 16'h1111, 10, cl, nz);
    master_half(1'b0, 16'h2222, 32, cr, nz);
    chk("f6_ferr_cnt", n_ferr, f0 + 1);
    chk("f6_rxv_cnt", n_rxv, r0);
    chk("f6_lft_rx", 32'(bus.lft_rx), 32'h0C0C);
    chk("f6_rht_rx", 32'(bus.rht_rx), 32'h0303);
    master_frame(16'h9ABC, 16'hDEF0, cl, cr, nz);
    chk("f7_rxv_cnt", n_rxv, r0 + 1);
    chk("f7_lft_rx", 32'(bus.lft_rx), 32'h9ABC);
    chk("f7_rht_rx", 32'(bus.rht_rx), 32'hDEF0);
    chk("f7_ferr_cnt", n_ferr, f0 + 1);

    // RSTn soft reset for 200 clks in the right half
    bus.lft_tx = 16'hFFFF;
    bus.rht_tx = 16'hFFFF;
    a0 = n_ack;
    r0 = n_rxv;
    fork
      master_frame(16'h1234, 16'h5678, cl, cr, nz);
      begin
        repeat (560) @(negedge clk);
        bus.RSTn = 1'b0;
        repeat (100) @(negedge clk);
        chk("soft_sdout", 32'(bus.SDout), 32'd0);
        chk("soft_lft_rx", 32'(bus.lft_rx), 32'd0);
        repeat (100) @(negedge clk);
        bus.RSTn = 1'b1;
      end
    join
    chk("f8_rxv_cnt", n_rxv, r0);
    chk("f8_ack_cnt", n_ack, a0 + 1);
    chk("f8_rht_rx", 32'(bus.rht_rx), 32'd0);
    bus.lft_tx = 16'h5A5A;
    bus.rht_tx = 16'hC3C3;
    master_frame(16'h4321, 16'h8765, cl, cr, nz);
    chk("f9_rxv_cnt", n_rxv, r0 + 1);
    chk("f9_lft_rx", 32'(bus.lft_rx), 32'h4321);
    chk("f9_rht_rx", 32'(bus.rht_rx), 32'h8765);
    chk("f9_cap_l", 32'(cl), 32'h5A5A);
    chk("f9_cap_r", 32'(cr), 32'hC3C3);
    chk("f9_ack_cnt", n_ack, a0 + 2);

    // loopback, 8 back-to-back frames of incrementing samples
    loopback = 1'b1;
    a0 = n_ack;
    f0 = n_ferr;
    for (int k = 0; k < 8; k++) begin
      lv = 16'h0100 + 16'(2 * k);
      rv = lv + 16'd1;
      bus.lft_tx = lv;
      bus.rht_tx = rv;
      master_frame(16'h0000, 16'h0000, cl, cr, nz);
      chk("lb_lft", 32'(mon_l), 32'(lv));
      chk("lb_rht", 32'(mon_r), 32'(rv));
      chk("lb_cap_l", 32'(cl), 32'(lv));
      if (k > 0) chk("lb_period", t_rxv - t_prev, 32'd1024);
    end
    chk("lb_ack_cnt", n_ack, a0 + 8);
    chk("lb_ferr_cnt", n_ferr, f0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
